// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between CPU writeback and round-robin peripheral writers
module regfile_write_arbiter #(
  parameter int NUM_IO = 3,
  parameter int RANDOM_REG = 29,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 cpu_we,
  input  logic [4:0]           cpu_reg,
  input  logic [31:0]          cpu_data,
  input  logic [NUM_IO-1:0]    io_req,
  input  logic [5*NUM_IO-1:0]  io_reg,
  input  logic [32*NUM_IO-1:0] io_data,
  output logic [NUM_IO-1:0]    io_ack,
  input  logic                 starve_clear,
  output logic                 ctrl_writeEnable,
  output logic [4:0]           ctrl_writeReg,
  output logic [31:0]          data_writeReg,
  output logic                 io_starved,
  output logic                 dropped_write
);
  localparam int PW = $clog2(NUM_IO);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [PW-1:0] rr_ptr, win, idx;
  logic [CW-1:0] cnt;
  logic [NUM_IO-1:0] elig;
  logic [4:0] regs [NUM_IO];
  logic [31:0] datas [NUM_IO];
  logic found, grant, has_win, prot, blocked, hit;
  logic [4:0] sel_reg;
  logic [31:0] sel_data;
  for (genvar g = 0; g < NUM_IO; g++) begin : g_unpack
    assign regs[g] = io_reg[5*g +: 5];
    assign datas[g] = io_data[32*g +: 32];
  end
  assign elig = io_req & ~io_ack;
  always_comb begin
    found = 1'b0;
    win = rr_ptr;
    idx = rr_ptr;
    for (int k = 1; k <= NUM_IO; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_IO);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign grant = !cpu_we && found;
  assign has_win = cpu_we || found;
  assign sel_reg = cpu_we ? cpu_reg : regs[win];
  assign sel_data = cpu_we ? cpu_data : datas[win];
  assign prot = sel_reg == 5'd0 || sel_reg == 5'(RANDOM_REG);
  assign blocked = cpu_we && |elig;
  assign hit = blocked && cnt == CW'(STARVE_LIMIT - 1);
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      dropped_write <= 1'b0;
      io_ack <= '0;
      io_starved <= 1'b0;
      rr_ptr <= PW'(NUM_IO - 1);
      cnt <= '0;
    end else begin
      ctrl_writeEnable <= has_win && !prot;
      dropped_write <= has_win && prot;
      ctrl_writeReg <= has_win ? sel_reg : ctrl_writeReg;
      data_writeReg <= has_win ? sel_data : data_writeReg;
      io_ack <= grant ? NUM_IO'(1) << win : '0;
      rr_ptr <= grant ? win : rr_ptr;
      cnt <= !blocked ? '0 : cnt == CW'(STARVE_LIMIT) ? cnt : cnt + 1'b1;
      io_starved <= hit ? 1'b1 : starve_clear ? 1'b0 : io_starved;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of priority, round-robin, filtering, starvation and reset abort
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic ctrl_reset, cpu_we, starve_clear;
  logic [4:0] cpu_reg;
  logic [31:0] cpu_data;
  logic [2:0] io_req, io_ack;
  logic [14:0] io_reg;
  logic [95:0] io_data;
  logic ctrl_writeEnable, io_starved, dropped_write;
  logic [4:0] ctrl_writeReg;
  logic [31:0] data_writeReg;
  int total = 0;
  int bad = 0;
  regfile_write_arbiter #(.NUM_IO(3), .RANDOM_REG(29), .STARVE_LIMIT(16)) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .cpu_we(cpu_we),
    .cpu_reg(cpu_reg),
    .cpu_data(cpu_data),
    .io_req(io_req),
    .io_reg(io_reg),
    .io_data(io_data),
    .io_ack(io_ack),
    .starve_clear(starve_clear),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .io_starved(io_starved),
    .dropped_write(dropped_write)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    ctrl_reset = 1'b0;
    cpu_we = 1'b0;
    cpu_reg = 5'd0;
    cpu_data = 32'h0;
    starve_clear = 1'b0;
    io_req = 3'b111;
    io_reg = {5'd12, 5'd11, 5'd10};
    io_data = {32'hC2, 32'hB1, 32'hA0};
    tick;
    tick;
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_reg", ctrl_writeReg, 0);
    chk("rst_data", data_writeReg, 0);
    chk("rst_ack", io_ack, 0);
    chk("rst_starved", io_starved, 0);
    chk("rst_dropped", dropped_write, 0);
    ctrl_reset = 1'b1;
    tick;
    chk("rr0_ack", io_ack, 3'b001);
    chk("rr0_we", ctrl_writeEnable, 1);
    chk("rr0_reg", ctrl_writeReg, 10);
    chk("rr0_data", data_writeReg, 32'hA0);
    tick;
    chk("rr1_ack", io_ack, 3'b010);
    chk("rr1_reg", ctrl_writeReg, 11);
    tick;
    chk("rr2_ack", io_ack, 3'b100);
    chk("rr2_data", data_writeReg, 32'hC2);
    tick;
    chk("rr3_ack", io_ack, 3'b001);
    chk("rr3_reg", ctrl_writeReg, 10);
    io_req = 3'b010;
    cpu_we = 1'b1;
    cpu_reg = 5'd5;
    cpu_data = 32'hDEADBEEF;
    tick;
    chk("cpu_we", ctrl_writeEnable, 1);
    chk("cpu_reg", ctrl_writeReg, 5);
    chk("cpu_data", data_writeReg, 32'hDEADBEEF);
    chk("cpu_ack", io_ack, 0);
    cpu_we = 1'b0;
    tick;
    chk("io1_ack", io_ack, 3'b010);
    chk("io1_reg", ctrl_writeReg, 11);
    chk("io1_data", data_writeReg, 32'hB1);
    io_req = 3'b000;
    tick;
    chk("idle_we", ctrl_writeEnable, 0);
    chk("idle_ack", io_ack, 0);
    chk("idle_reg_hold", ctrl_writeReg, 11);
    chk("idle_data_hold", data_writeReg, 32'hB1);
    io_reg = {5'd12, 5'd29, 5'd0};
    io_req = 3'b011;
    tick;
    chk("r0_ack", io_ack, 3'b001);
    chk("r0_we", ctrl_writeEnable, 0);
    chk("r0_dropped", dropped_write, 1);
    io_req = 3'b010;
    tick;
    chk("r29_ack", io_ack, 3'b010);
    chk("r29_we", ctrl_writeEnable, 0);
    chk("r29_dropped", dropped_write, 1);
    chk("r29_reg", ctrl_writeReg, 29);
    io_req = 3'b000;
    tick;
    chk("after_drop", dropped_write, 0);
    cpu_we = 1'b1;
    cpu_reg = 5'd0;
    tick;
    chk("cpu_r0_dropped", dropped_write, 1);
    chk("cpu_r0_we", ctrl_writeEnable, 0);
    io_reg = {5'd12, 5'd11, 5'd10};
    cpu_reg = 5'd7;
    cpu_data = 32'h1;
    io_req = 3'b100;
    for (int i = 0; i < 15; i++) tick;
    chk("starve_15", io_starved, 0);
    tick;
    chk("starve_16", io_starved, 1);
    tick;
    tick;
    chk("starve_sticky", io_starved, 1);
    chk("starve_no_ack", io_ack, 0);
    chk("starve_cpu_we", ctrl_writeEnable, 1);
    cpu_we = 1'b0;
    io_req = 3'b000;
    starve_clear = 1'b1;
    tick;
    chk("starve_clear", io_starved, 0);
    starve_clear = 1'b0;
    io_req = 3'b100;
    tick;
    chk("io2_ack", io_ack, 3'b100);
    chk("io2_reg", ctrl_writeReg, 12);
    chk("io2_data", data_writeReg, 32'hC2);
    chk("io2_starved", io_starved, 0);
    io_req = 3'b010;
    ctrl_reset = 1'b0;
    tick;
    chk("abort_ack", io_ack, 0);
    chk("abort_we", ctrl_writeEnable, 0);
    chk("abort_reg", ctrl_writeReg, 0);
    chk("abort_data", data_writeReg, 0);
    ctrl_reset = 1'b1;
    tick;
    chk("reserve_ack", io_ack, 3'b010);
    chk("reserve_we", ctrl_writeEnable, 1);
    chk("reserve_reg", ctrl_writeReg, 11);
    chk("reserve_data", data_writeReg, 32'hB1);
    io_req = 3'b000;
    tick;
    chk("final_ack", io_ack, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the processor writeback stage and NUM_IO peripheral writers (button/mole-hit capture, timer, score logic).
- The CPU writeback has absolute priority and is never stalled.
- Peripherals use a req/ack handshake and are served round-robin in cycles when the CPU is not writing.
- Outputs are registered and drive the register file's ctrl_writeEnable, ctrl_writeReg and data_writeReg directly. Writes to r0 and the hardware random register are filtered.

Parameters:
NUM_IO, 3, number of peripheral write requesters (2..8)
RANDOM_REG, 29, register index backed by the random source; writes are dropped
STARVE_LIMIT, 16, consecutive blocked cycles before the starvation flag sets

Ports:
clock  in  1  system clock; all state updates on rising edge
ctrl_reset  in  1  synchronous, active-low reset
cpu_we  in  1  CPU writeback write enable
cpu_reg  in  5  CPU destination register
cpu_data  in  32  CPU write data
io_req  in  NUM_IO  per-peripheral write request; held until acked
io_reg  in  5*NUM_IO  packed destination registers; slice i = bits [5i+4:5i]
io_data  in  32*NUM_IO  packed write data; slice i = bits [32i+31:32i]
io_ack  out  NUM_IO  one-cycle acknowledge per peripheral
starve_clear  in  1  clears io_starved
ctrl_writeEnable  out  1  register file write enable
ctrl_writeReg  out  5  register file write address
data_writeReg  out  32  register file write data
io_starved  out  1  sticky flag: a peripheral waited STARVE_LIMIT cycles
dropped_write  out  1  one-cycle pulse when a protected-register write was discarded

Behaviour:
- Reset: sampled on a clock edge with ctrl_reset=0. All outputs go to 0. rr_ptr=NUM_IO-1, so io0 wins first. Starve counter=0. Reset overrides all other inputs; in-flight requests are forgotten and requesters keep req high to be re-served.
- Per-cycle arbitration (combinational from the current inputs):
  - Eligible peripheral = io_req[i]=1 and io_ack[i]=0 this cycle. This mask prevents a double grant while the requester is still dropping req.
  - If cpu_we=1: winner=CPU and no peripheral is acked.
  - Else if any peripheral is eligible: winner is the first eligible index searching from rr_ptr+1 upward, wrapping modulo NUM_IO. rr_ptr updates to the winner.
  - Else: no winner.
- Output register, latency 1 cycle:
  - Next edge loads the winner's reg/data into ctrl_writeReg/data_writeReg.
  - ctrl_writeEnable=1 only if a winner exists and the destination is neither 0 nor RANDOM_REG.
  - With no winner, ctrl_writeEnable=0 and the address/data hold their previous values.
- io_ack: a peripheral winner gets io_ack[i]=1 in the same cycle its write appears on the outputs (one cycle after being chosen), for exactly one cycle. The requester may deassert req or present a new request after seeing ack.
- Protected targets: a write to r0 or RANDOM_REG from any source consumes the slot. The peripheral is still acked. ctrl_writeEnable=0 and dropped_write=1 in that output cycle.
- Starvation:
  - Counter increments each cycle where cpu_we=1 and at least one peripheral is eligible.
  - Counter clears on any cycle a peripheral is granted, or when no peripheral is eligible.
  - Counter saturates at STARVE_LIMIT; on reaching it, io_starved=1.
  - io_starved stays set until reset or starve_clear=1. If starve_clear and the set condition coincide, set wins.
- CPU and peripheral targeting the same register in the same cycle: the CPU write goes first and the peripheral write lands in a later slot, so the peripheral value ends last (intentional ordering).
- Requester inputs must be stable while req=1. Changes before ack are undefined behaviour, flagged by bench assertion.

Test Plan:
- Reset with ctrl_reset=0 for 2 cycles, io_req=3'b111 → all outputs 0. After release, first ack is io_ack=3'b001 with ctrl_writeReg=io_reg[0], 1 cycle after release.
- cpu_we=1, cpu_reg=5, cpu_data=32'hDEADBEEF, io_req=3'b010 → next cycle ctrl_writeEnable=1, reg=5, data=DEADBEEF, io_ack=0. With cpu_we=0 the following cycle, io1 is acked one cycle later.
- io_req=3'b111 held continuously, requesters re-requesting right after ack, cpu_we=0 → ack order 001,010,100,001 on consecutive cycles; no repeat grant during an ack cycle.
- io0 writes reg 0 and io1 writes reg 29 → both acked, ctrl_writeEnable=0 and dropped_write=1 in each output cycle.
- cpu_we=1 for 16 cycles with io_req[2]=1 → io_starved=1 after the 16th blocked cycle and stays set. starve_clear=1 clears it. cpu_we=0 then grants io2.
- Assert ctrl_reset=0 in the cycle io1 is chosen → no io_ack at the next edge, outputs 0. After release, io1 is served again with the correct data.
